// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg
//   Shared CPU widths and the IMEM boot controller state encoding.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int INST_ADDR_WIDTH = 10;
   localparam int INST_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      IMEM_IDLE  = 3'd0,
      IMEM_LOAD  = 3'd1,
      IMEM_DRAIN = 3'd2,
      IMEM_RUN   = 3'd3,
      IMEM_ERR   = 3'd4
   } imem_ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_ld_csum.sv
// ============================================================================
// imem_ld_csum
//   Running modulo-2**DATA_W sum of loaded words.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module imem_ld_csum
   import cpu_pkg::*;
#(
   parameter int DATA_W = INST_DATA_WIDTH
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              i_clr,
   input  logic              i_add,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_sum_next
);

   logic [DATA_W-1:0] r_sum;

   // Sum including the word on the current handshake, so the last word counts.
   assign o_sum_next = r_sum + i_data;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         r_sum <= '0;
      else if (i_clr)
         r_sum <= '0;
      else if (i_add)
         r_sum <= o_sum_next;
   end

endmodule

`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
// ============================================================================
// imem_boot_ctrl
//   IMEM boot sequencer and port arbiter: loader writes in LOAD, IF reads in RUN.
//   Optional load checksum: IMEM_LOAD_CHECKSUM_EN.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module imem_boot_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_WIDTH,
   parameter int DATA_W = INST_DATA_WIDTH
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Ld_Req_i,
   input  logic              Ld_Valid_i,
   input  logic [DATA_W-1:0] Ld_Data_i,
   input  logic              Ld_Last_i,
   input  logic [DATA_W-1:0] Ld_Csum_i,
   output logic              Ld_Ready_o,
   input  logic              Halt_i,
   input  logic              If_Imem_En_i,
   input  logic [ADDR_W-1:0] If_Imem_Addr_i,
   output logic [DATA_W-1:0] If_Imem_Data_o,
   output logic              Start_o,
   output logic              Mem_En_o,
   output logic              Mem_We_o,
   output logic [ADDR_W-1:0] Mem_Addr_o,
   output logic [DATA_W-1:0] Mem_Wdata_o,
   input  logic [DATA_W-1:0] Mem_Rdata_i,
   output logic [2:0]        State_o,
   output logic [ADDR_W:0]   Ld_Count_o,
   output logic              Err_o
);

   localparam logic [ADDR_W:0]   C_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   C_ONE       = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

   imem_ctrl_state_e  r_state;
   logic              r_start;
   logic              r_err;
   logic [ADDR_W:0]   r_count;

   logic              w_ld_hs;
   logic              w_ld_start;
   logic              w_csum_ok;

   assign w_ld_hs    = (r_state == IMEM_LOAD) && Ld_Valid_i;
   assign w_ld_start = ((r_state == IMEM_IDLE) || (r_state == IMEM_ERR)) && Ld_Req_i;

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [DATA_W-1:0] w_sum_next;

   imem_ld_csum #(
      .DATA_W (DATA_W)
   ) u_ld_csum (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .i_clr      (w_ld_start),
      .i_add      (w_ld_hs),
      .i_data     (Ld_Data_i),
      .o_sum_next (w_sum_next)
   );

   assign w_csum_ok = (w_sum_next == Ld_Csum_i);
`else
   logic [DATA_W-1:0] w_csum_unused;
   assign w_csum_unused = Ld_Csum_i;
   assign w_csum_ok     = 1'b1;
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= IMEM_IDLE;
         r_start <= 1'b0;
         r_err   <= 1'b0;
         r_count <= '0;
      end else begin
         case (r_state)
            IMEM_IDLE, IMEM_ERR: begin
               if (Ld_Req_i) begin
                  r_state <= IMEM_LOAD;
                  r_count <= '0;
                  r_err   <= 1'b0;
               end
            end
            IMEM_LOAD: begin
               if (w_ld_hs) begin
                  if (r_count != C_DEPTH)
                     r_count <= r_count + C_ONE;
                  if (Ld_Last_i) begin
                     if (w_csum_ok) begin
                        r_state <= IMEM_DRAIN;
                     end else begin
                        r_state <= IMEM_ERR;
                        r_err   <= 1'b1;
                     end
                  end else if (r_count[ADDR_W-1:0] == C_LAST_ADDR) begin
                     // Final SRAM word written without Last: program too large.
                     r_state <= IMEM_ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
            IMEM_DRAIN: begin
               r_state <= IMEM_RUN;
               r_start <= 1'b1;
            end
            IMEM_RUN: begin
               if (Halt_i) begin
                  r_state <= IMEM_IDLE;
                  r_start <= 1'b0;
               end
            end
            default: begin
               r_state <= IMEM_IDLE;
               r_start <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      Mem_En_o    = 1'b0;
      Mem_We_o    = 1'b0;
      Mem_Addr_o  = '0;
      Mem_Wdata_o = '0;
      if (w_ld_hs) begin
         Mem_En_o    = 1'b1;
         Mem_We_o    = 1'b1;
         Mem_Addr_o  = r_count[ADDR_W-1:0];
         Mem_Wdata_o = Ld_Data_i;
      end else if (r_state == IMEM_RUN) begin
         Mem_En_o    = If_Imem_En_i;
         Mem_Addr_o  = If_Imem_Addr_i;
      end
   end

   // Unregistered return path keeps the IF stage's one-cycle read latency.
   assign If_Imem_Data_o = Mem_Rdata_i;
   assign Ld_Ready_o     = (r_state == IMEM_LOAD);
   assign Start_o        = r_start;
   assign Err_o          = r_err;
   assign Ld_Count_o     = r_count;
   assign State_o        = r_state;

endmodule

`default_nettype wire
